down_timer_ctrl: RTL and testbench

//  Sequencer for a loadable 4-bit down counter. It accepts a start value through a

---
 rtl/down_timer_pkg.sv | 22 ++
 rtl/down_counter_core.sv | 34 +++
 rtl/down_timer_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_down_timer_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and helpers for the down_timer_ctrl sequencer.
//   state_e   : controller states (IDLE/RUN/PAUSE/DONE)
//   WIDTH_DEF : default counter width
//   presc_w() : prescaler register width for a given PRESCALE
package down_timer_pkg;

  localparam int unsigned WIDTH_DEF    = 4;
  localparam int unsigned PRESCALE_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits needed to hold prescaler values 0..PRESCALE
  function automatic int unsigned presc_w(input int unsigned prescale);
    return $clog2(prescale + 1);
  endfunction

endpackage

// File: rtl/down_counter_core.sv
// Synchronous loadable down counter; load has priority over dec.
// Ports:
//   clk, res       : clock, async active-low reset
//   load, load_val : synchronous load of a new value
//   dec            : decrement by one (caller never decrements past zero)
//   q              : current value (registered)
//   zero           : registered q==0 flag, kept in step with q
module down_counter_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  // zero is predicted from the value being written so it never lags q
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q    <= '0;
      zero <= 1'b1;
    end else if (load) begin
      q    <= load_val;
      zero <= (load_val == '0);
    end else if (dec) begin
      q    <= q - WIDTH'(1);
      zero <= (q == WIDTH'(1));
    end
  end

endmodule

// File: rtl/down_timer_ctrl.sv
// Sequencer for a loadable down counter: config handshake, start, pause,
// abort, optional auto-reload and terminal-count events.
// Ports:
//   clk, res             : clock, async active-low reset
//   cfg_valid/cfg_ready  : config handshake (ready only in IDLE and DONE)
//   cfg_load, cfg_auto   : start/reload value and periodic-mode select
//   start, pause, abort  : run control (priority abort > cfg > start > pause)
//   count                : current counter value
//   busy                 : high in RUN or PAUSE
//   tc_pulse             : one-cycle pulse per terminal-count tick
//   done                 : sticky one-shot completion flag
module down_timer_ctrl
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned PRESCALE = PRESCALE_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic             cfg_auto,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  state_e             state_q, state_nxt;
  logic [WIDTH-1:0]   load_q, load_nxt;
  logic               auto_q, auto_nxt;
  logic               tc_q, tc_nxt;
  logic               done_q, done_nxt;
  logic               ready_q, ready_nxt;
  logic               busy_q, busy_nxt;

  logic               cnt_load;
  logic [WIDTH-1:0]   cnt_load_val;
  logic               cnt_dec;
  logic [WIDTH-1:0]   cnt_q;
  logic               cnt_zero;

  logic               presc_clr;
  logic               run_go;
  logic               presc_wrap;
  logic               cfg_hs;

  // Counter datapath
  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .res      (res),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .q        (cnt_q),
    .zero     (cnt_zero)
  );

  // Prescaler: only built when ticks are slower than the clock
  if (PRESCALE > 1) begin : g_presc
    localparam int unsigned PRESC_W = presc_w(PRESCALE);
    logic [PRESC_W-1:0] presc_q;

    always_ff @(posedge clk or negedge res) begin
      if (!res) begin
        presc_q <= '0;
      end else if (presc_clr) begin
        presc_q <= '0;
      end else if (run_go) begin
        presc_q <= presc_wrap ? '0 : presc_q + PRESC_W'(1);
      end
    end

    assign presc_wrap = (presc_q == PRESC_W'(PRESCALE - 1));
  end else begin : g_no_presc
    logic presc_unused;
    assign presc_unused = presc_clr ^ run_go;
    assign presc_wrap   = 1'b1;
  end

  // Config is accepted in exactly the states where cfg_ready is high
  assign cfg_hs = cfg_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State and output registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
      auto_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      load_q  <= load_nxt;
      auto_q  <= auto_nxt;
      tc_q    <= tc_nxt;
      done_q  <= done_nxt;
      ready_q <= ready_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Next-state and counter control
  always_comb begin
    state_nxt    = state_q;
    load_nxt     = load_q;
    auto_nxt     = auto_q;
    tc_nxt       = 1'b0;
    done_nxt     = done_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    presc_clr    = 1'b0;
    run_go       = 1'b0;

    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_load  = 1'b1;
      presc_clr = 1'b1;
      done_nxt  = 1'b0;
    end else if (cfg_hs) begin
      state_nxt    = ST_IDLE;
      load_nxt     = cfg_load;
      auto_nxt     = cfg_auto;
      cnt_load     = 1'b1;
      cnt_load_val = cfg_load;
      done_nxt     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nxt    = ST_RUN;
            cnt_load     = 1'b1;
            cnt_load_val = load_q;
            presc_clr    = 1'b1;
            done_nxt     = 1'b0;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_nxt = ST_PAUSE;
          end else begin
            run_go = 1'b1;
            if (presc_wrap) begin
              if (!cnt_zero) begin
                cnt_dec = 1'b1;
              end else begin
                // Terminal count: reload in periodic mode, else finish
                tc_nxt = 1'b1;
                if (auto_q) begin
                  cnt_load     = 1'b1;
                  cnt_load_val = load_q;
                end else begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
                end
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
    busy_nxt  = (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign tc_pulse  = tc_q;
  assign done      = done_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Self-checking bench for down_timer_ctrl. Two instances (PRESCALE=1 and 3)
// share all inputs; directed scenarios check against hand-derived values and a
// randomized phase checks both against a behavioural model.
module tb_down_timer_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk;
  logic       res;
  logic       cfg_valid;
  logic [3:0] cfg_load;
  logic       cfg_auto;
  logic       start;
  logic       pause;
  logic       abort;

  logic       p1_ready, p1_busy, p1_tc, p1_done;
  logic [3:0] p1_count;
  logic       p3_ready, p3_busy, p3_tc, p3_done;
  logic [3:0] p3_count;
  logic [7:0] p1_obs, p3_obs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int st;
    int cnt;
    int ld;
    bit au;
    int presc;
    bit tc;
    bit dn;
  } mdl_t;

  down_timer_ctrl #(.WIDTH(4), .PRESCALE(1)) u_p1 (
    .clk(clk), .res(res), .cfg_valid(cfg_valid), .cfg_ready(p1_ready),
    .cfg_load(cfg_load), .cfg_auto(cfg_auto), .start(start), .pause(pause),
    .abort(abort), .count(p1_count), .busy(p1_busy), .tc_pulse(p1_tc),
    .done(p1_done)
  );

  down_timer_ctrl #(.WIDTH(4), .PRESCALE(3)) u_p3 (
    .clk(clk), .res(res), .cfg_valid(cfg_valid), .cfg_ready(p3_ready),
    .cfg_load(cfg_load), .cfg_auto(cfg_auto), .start(start), .pause(pause),
    .abort(abort), .count(p3_count), .busy(p3_busy), .tc_pulse(p3_tc),
    .done(p3_done)
  );

  assign p1_obs = {p1_count, p1_ready, p1_busy, p1_tc, p1_done};
  assign p3_obs = {p3_count, p3_ready, p3_busy, p3_tc, p3_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation vector {count, cfg_ready, busy, tc_pulse, done}
  function automatic logic [7:0] ev(int c, bit r, bit b, bit t, bit d);
    return {4'(c), r, b, t, d};
  endfunction

  // Behavioural model: one clock edge applying the specification's rules
  function automatic mdl_t step(mdl_t m, int p);
    mdl_t n = m;
    bit   rdy = (m.st == M_IDLE) || (m.st == M_DONE);
    n.tc = 1'b0;
    if (!res) begin
      n = '0;
      n.st = M_IDLE;
    end else if (abort) begin
      n.st = M_IDLE; n.cnt = 0; n.presc = 0; n.dn = 1'b0;
    end else if (cfg_valid && rdy) begin
      n.ld = int'(cfg_load); n.au = cfg_auto; n.cnt = int'(cfg_load);
      n.dn = 1'b0; n.st = M_IDLE;
    end else if (start && rdy) begin
      n.cnt = m.ld; n.presc = 0; n.dn = 1'b0; n.st = M_RUN;
    end else if (m.st == M_RUN) begin
      if (pause) begin
        n.st = M_PAUSE;
      end else if (m.presc == p - 1) begin
        n.presc = 0;
        if (m.cnt != 0) begin
          n.cnt = m.cnt - 1;
        end else begin
          n.tc = 1'b1;
          if (m.au) n.cnt = m.ld;
          else begin n.st = M_DONE; n.dn = 1'b1; end
        end
      end else begin
        n.presc = m.presc + 1;
      end
    end else if (m.st == M_PAUSE && !pause) begin
      n.st = M_RUN;
    end
    return n;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int l, input bit a);
    cfg_valid = 1'b1; cfg_load = 4'(l); cfg_auto = a;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_v;
    exp_v = ev(0, 1, 0, 0, 0);
    res = 1'b0; cfg_valid = 1'b0; cfg_load = '0; cfg_auto = 1'b0;
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (2) cyc();
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL reset_p1: got %h want %h", p1_obs, exp_v); end
    checks++;
    if (p3_obs !== exp_v) begin errors++; $display("FAIL reset_p3: got %h want %h", p3_obs, exp_v); end
    res = 1'b1;
    cyc();
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL reset_release: got %h want %h", p1_obs, exp_v); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp_v;
    do_cfg(5, 0);
    do_start();
    cyc(); cyc();
    exp_v = ev(3, 0, 1, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL midrun_pre: got %h want %h", p1_obs, exp_v); end
    // Assert reset between clock edges; outputs must clear without an edge
    #2 res = 1'b0;
    #1;
    exp_v = ev(0, 1, 0, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL midrun_async_p1: got %h want %h", p1_obs, exp_v); end
    checks++;
    if (p3_obs !== exp_v) begin errors++; $display("FAIL midrun_async_p3: got %h want %h", p3_obs, exp_v); end
    cyc(); cyc();
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL midrun_held: got %h want %h", p1_obs, exp_v); end
    res = 1'b1;
    do_start();
    // load_q was cleared by reset, so a bare start counts from 0
    exp_v = ev(0, 0, 1, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL midrun_loadq_cleared: got %h want %h", p1_obs, exp_v); end
    do_abort();
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_v;
    int         tcs = 0;
    do_abort();
    do_cfg(5, 0);
    do_start();
    exp_v = ev(5, 0, 1, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL oneshot_start: got %h want %h", p1_obs, exp_v); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      exp_v = ev(5 - k, 0, 1, 0, 0);
      tcs += int'(p1_tc);
      checks++;
      if (p1_obs !== exp_v) begin errors++; $display("FAIL oneshot_cnt%0d: got %h want %h", k, p1_obs, exp_v); end
    end
    cyc();
    tcs += int'(p1_tc);
    exp_v = ev(0, 1, 0, 1, 1);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL oneshot_tc: got %h want %h", p1_obs, exp_v); end
    cyc();
    tcs += int'(p1_tc);
    exp_v = ev(0, 1, 0, 0, 1);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL oneshot_sticky: got %h want %h", p1_obs, exp_v); end
    checks++;
    if (tcs !== 1) begin errors++; $display("FAIL oneshot_tc_count: got %0d want 1", tcs); end
  endtask

  task automatic test_autoreload();
    logic [7:0] exp_v;
    int         c;
    do_abort();
    do_cfg(2, 1);
    do_start();
    exp_v = ev(2, 0, 1, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL auto_start: got %h want %h", p1_obs, exp_v); end
    for (int k = 1; k <= 9; k++) begin
      cyc();
      c = (k % 3 == 0) ? 2 : 2 - (k % 3);
      exp_v = ev(c, 0, 1, (k % 3 == 0), 0);
      checks++;
      if (p1_obs !== exp_v) begin errors++; $display("FAIL auto_cyc%0d: got %h want %h", k, p1_obs, exp_v); end
    end
    do_abort();
    exp_v = ev(0, 1, 0, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL auto_abort: got %h want %h", p1_obs, exp_v); end
  endtask

  task automatic test_prescale_pause();
    int         ec [17] = '{3, 3, 2, 2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0};
    logic [7:0] exp_v;
    bit         last;
    do_abort();
    do_cfg(3, 0);
    do_start();
    exp_v = ev(3, 0, 1, 0, 0);
    checks++;
    if (p3_obs !== exp_v) begin errors++; $display("FAIL presc_start: got %h want %h", p3_obs, exp_v); end
    for (int k = 1; k <= 17; k++) begin
      pause = (k >= 4) && (k <= 7);
      cyc();
      last = (k == 17);
      exp_v = ev(ec[k-1], last, !last, last, last);
      checks++;
      if (p3_obs !== exp_v) begin errors++; $display("FAIL presc_cyc%0d: got %h want %h", k, p3_obs, exp_v); end
    end
    pause = 1'b0;
    cyc();
    exp_v = ev(0, 1, 0, 0, 1);
    checks++;
    if (p3_obs !== exp_v) begin errors++; $display("FAIL presc_after: got %h want %h", p3_obs, exp_v); end
  endtask

  task automatic test_boundaries();
    logic [7:0] exp_v;
    // Load 0: terminal count on the very first tick
    do_abort();
    do_cfg(0, 0);
    do_start();
    exp_v = ev(0, 0, 1, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL bnd_zero_start: got %h want %h", p1_obs, exp_v); end
    cyc();
    exp_v = ev(0, 1, 0, 1, 1);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL bnd_zero_tc: got %h want %h", p1_obs, exp_v); end
    // Load 15: full range without wrap
    do_abort();
    do_cfg(15, 0);
    do_start();
    for (int k = 1; k <= 15; k++) begin
      cyc();
      exp_v = ev(15 - k, 0, 1, 0, 0);
      checks++;
      if (p1_obs !== exp_v) begin errors++; $display("FAIL bnd_max_cyc%0d: got %h want %h", k, p1_obs, exp_v); end
    end
    cyc();
    exp_v = ev(0, 1, 0, 1, 1);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL bnd_max_tc: got %h want %h", p1_obs, exp_v); end
    // Config offered while running is refused
    do_abort();
    do_cfg(7, 0);
    do_start();
    cfg_valid = 1'b1; cfg_load = 4'd3; cfg_auto = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    exp_v = ev(6, 0, 1, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL bnd_cfg_run: got %h want %h", p1_obs, exp_v); end
    do_abort();
    do_start();
    exp_v = ev(7, 0, 1, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL bnd_cfg_nolatch: got %h want %h", p1_obs, exp_v); end
    repeat (8) cyc();
    exp_v = ev(0, 1, 0, 1, 1);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL bnd_cfg_auto_kept: got %h want %h", p1_obs, exp_v); end
  endtask

  task automatic test_priority();
    logic [7:0] exp_v;
    do_abort();
    do_cfg(6, 0);
    do_start();
    cyc();
    abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    exp_v = ev(0, 1, 0, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL prio_abort_start: got %h want %h", p1_obs, exp_v); end
    cyc();
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL prio_abort_idle: got %h want %h", p1_obs, exp_v); end
    // Handshake and start together in DONE: config wins, start dropped
    do_cfg(0, 0);
    do_start();
    cyc();
    exp_v = ev(0, 1, 0, 1, 1);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL prio_reach_done: got %h want %h", p1_obs, exp_v); end
    cfg_valid = 1'b1; cfg_load = 4'd9; cfg_auto = 1'b0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    exp_v = ev(9, 1, 0, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL prio_cfg_start: got %h want %h", p1_obs, exp_v); end
    cyc();
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL prio_cfg_stays: got %h want %h", p1_obs, exp_v); end
    do_abort();
    do_start();
    exp_v = ev(9, 0, 1, 0, 0);
    checks++;
    if (p1_obs !== exp_v) begin errors++; $display("FAIL prio_load_retained: got %h want %h", p1_obs, exp_v); end
  endtask

  task automatic test_random();
    mdl_t       m1, m3;
    logic [7:0] e1, e3;
    res = 1'b0;
    cyc();
    m1 = '0; m3 = '0;
    m1.st = M_IDLE; m3.st = M_IDLE;
    res = 1'b1; abort = 1'b0; start = 1'b0; cfg_valid = 1'b0; pause = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      res       = ($urandom_range(0, 299) != 0);
      abort     = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_load  = 4'($urandom_range(0, 15));
      cfg_auto  = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      cyc();
      m1 = step(m1, 1);
      m3 = step(m3, 3);
      e1 = ev(m1.cnt, (m1.st == M_IDLE) || (m1.st == M_DONE),
              (m1.st == M_RUN) || (m1.st == M_PAUSE), m1.tc, m1.dn);
      e3 = ev(m3.cnt, (m3.st == M_IDLE) || (m3.st == M_DONE),
              (m3.st == M_RUN) || (m3.st == M_PAUSE), m3.tc, m3.dn);
      checks++;
      if (p1_obs !== e1) begin errors++; $display("FAIL rand_p1 cyc%0d: got %h want %h", i, p1_obs, e1); end
      checks++;
      if (p3_obs !== e3) begin errors++; $display("FAIL rand_p3 cyc%0d: got %h want %h", i, p3_obs, e3); end
    end
    res = 1'b1; abort = 1'b0; start = 1'b0; cfg_valid = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_oneshot();
    test_autoreload();
    test_prescale_pause();
    test_boundaries();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
